a23_gc_run_ctrl: RTL and testbench

// Run sequencer for the garbled a23 system (core + unified memory). Holds the core in

---
 rtl/a23_gc_run_ctrl_pkg.sv | 14 +
 rtl/a23_sat_counter.sv | 35 +++
 rtl/a23_gc_run_ctrl.sv | 118 +++++++++++
 tb/tb_a23_gc_run_ctrl.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/a23_gc_run_ctrl_pkg.sv
// a23_gc_run_ctrl_pkg
// Shared definitions for the a23 run sequencer: run-state encodings and the
// state register width. The harness monitors import the same constants, so
// they must stay at IDLE=0, RESET=1, RUN=2, DONE=3.
package a23_gc_run_ctrl_pkg;

  localparam int STATE_W = 2;

  localparam logic [STATE_W-1:0] ST_IDLE  = 2'd0;
  localparam logic [STATE_W-1:0] ST_RESET = 2'd1;
  localparam logic [STATE_W-1:0] ST_RUN   = 2'd2;
  localparam logic [STATE_W-1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/a23_sat_counter.sv
// a23_sat_counter
// Up-counter that sticks at all-ones instead of wrapping.
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset (count -> 0)
//   clear      synchronous clear (count -> 0), takes priority over enable
//   enable     advance the count by one this cycle (saturating)
//   count      registered count value
//   count_inc  value count would take if enabled now (combinational)
module a23_sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         enable,
  output logic [W-1:0] count,
  output logic [W-1:0] count_inc
);

  // Exposed so the parent can compare against the budget using the value the
  // current cycle will produce, without a second adder.
  always_comb begin
    count_inc = (&count) ? count : count + W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count_inc;
    end
  end

endmodule

// File: rtl/a23_gc_run_ctrl.sv
// a23_gc_run_ctrl
// Run sequencer for the garbled a23 system. Holds the core in reset until a
// start is accepted, releases it after a short reset phase, counts RUN cycles
// and stops on core terminate or budget expiry.
// Ports:
//   clk           system clock
//   rst           synchronous active-high reset, priority over all inputs
//   i_start       start request (honoured in IDLE and DONE only)
//   i_max_cycles  RUN-cycle budget, latched on accepted start, 0 = unlimited
//   i_terminate   terminate from the core, sampled only in RUN
//   o_core_rst    reset to core and memory
//   o_busy        high in RESET and RUN
//   o_done        high in DONE until next accepted start or rst
//   o_timeout     with o_done: 1 = budget expired, 0 = core terminated
//   o_cycle_cnt   RUN cycles elapsed, saturating, frozen in DONE
module a23_gc_run_ctrl
  import a23_gc_run_ctrl_pkg::*;
#(
  parameter int RST_CYCLES = 2,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [CNT_W-1:0] i_max_cycles,
  input  logic             i_terminate,
  output logic             o_core_rst,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_timeout,
  output logic [CNT_W-1:0] o_cycle_cnt
);

  localparam int RC_W = $clog2(RST_CYCLES + 1);

  logic [STATE_W-1:0] state_reg, state_next;
  logic [RC_W-1:0]    rst_cnt_reg, rst_cnt_next;
  logic [CNT_W-1:0]   budget_reg, budget_next;
  logic               timeout_next;
  logic               cnt_clear, cnt_enable;
  logic [CNT_W-1:0]   cnt_inc;

  a23_sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk       (clk),
    .rst       (rst),
    .clear     (cnt_clear),
    .enable    (cnt_enable),
    .count     (o_cycle_cnt),
    .count_inc (cnt_inc)
  );

  always_comb begin
    state_next   = state_reg;
    rst_cnt_next = rst_cnt_reg;
    budget_next  = budget_reg;
    timeout_next = o_timeout;
    cnt_clear    = 1'b0;
    cnt_enable   = 1'b0;
    case (state_reg)
      ST_IDLE, ST_DONE: begin
        if (i_start) begin
          state_next   = ST_RESET;
          budget_next  = i_max_cycles;
          rst_cnt_next = '0;
          timeout_next = 1'b0;
          cnt_clear    = 1'b1;
        end
      end
      ST_RESET: begin
        // The entry edge plus RST_CYCLES further cycles keep core_rst high,
        // so the core sees release RST_CYCLES+1 edges after the start edge.
        if (rst_cnt_reg == RC_W'(RST_CYCLES)) begin
          state_next = ST_RUN;
        end else begin
          rst_cnt_next = rst_cnt_reg + RC_W'(1);
        end
      end
      ST_RUN: begin
        cnt_enable = 1'b1;
        // Terminate is checked first so a same-cycle expiry reports success.
        if (i_terminate) begin
          state_next   = ST_DONE;
          timeout_next = 1'b0;
        end else if ((budget_reg != '0) && (cnt_inc == budget_reg)) begin
          state_next   = ST_DONE;
          timeout_next = 1'b1;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      rst_cnt_reg <= '0;
      budget_reg  <= '0;
      o_core_rst  <= 1'b1;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_timeout   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      rst_cnt_reg <= rst_cnt_next;
      budget_reg  <= budget_next;
      o_timeout   <= timeout_next;
      // Status outputs are registered from the next state so they line up
      // with the state register. Core reset stays low in DONE so memory
      // contents remain readable by the harness.
      o_core_rst  <= (state_next == ST_IDLE) || (state_next == ST_RESET);
      o_busy      <= (state_next == ST_RESET) || (state_next == ST_RUN);
      o_done      <= (state_next == ST_DONE);
    end
  end

endmodule

// File: tb/tb_a23_gc_run_ctrl.sv
module tb_a23_gc_run_ctrl;

  localparam int RST_CYCLES = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  always #5 clk = ~clk;

  // 32-bit instance
  logic        start = 1'b0;
  logic        term  = 1'b0;
  logic [31:0] max_cycles = '0;
  logic        core_rst, busy, done, timeout;
  logic [31:0] cycle_cnt;

  // 4-bit instance for saturation
  logic        start4 = 1'b0;
  logic        term4  = 1'b0;
  logic [3:0]  max4   = '0;
  logic        core_rst4, busy4, done4, timeout4;
  logic [3:0]  cycle_cnt4;

  int n_cmp = 0;
  int n_err = 0;

  a23_gc_run_ctrl #(.RST_CYCLES(RST_CYCLES), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .i_start(start), .i_max_cycles(max_cycles),
    .i_terminate(term), .o_core_rst(core_rst), .o_busy(busy), .o_done(done),
    .o_timeout(timeout), .o_cycle_cnt(cycle_cnt)
  );

  a23_gc_run_ctrl #(.RST_CYCLES(RST_CYCLES), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .i_start(start4), .i_max_cycles(max4),
    .i_terminate(term4), .o_core_rst(core_rst4), .o_busy(busy4), .o_done(done4),
    .o_timeout(timeout4), .o_cycle_cnt(cycle_cnt4)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, " core_rst"}, core_rst, 1);
    check({tag, " busy"}, busy, 0);
    check({tag, " done"}, done, 0);
    check({tag, " timeout"}, timeout, 0);
    check({tag, " cnt"}, cycle_cnt, 0);
  endtask

  // One complete run from IDLE or DONE. b = budget (0 = unlimited),
  // k = RUN cycle on which terminate is raised (0 = never).
  task automatic do_run(input int b, input int k);
    int  stop_at;
    logic exp_to;
    // Reference rule: terminate wins whenever it arrives no later than expiry.
    if (k != 0 && (b == 0 || k <= b)) begin
      stop_at = k; exp_to = 1'b0;
    end else begin
      stop_at = b; exp_to = 1'b1;
    end
    $display("run: budget=%0d term_at=%0d -> stop=%0d timeout=%0d", b, k, stop_at, exp_to);
    start = 1'b1; max_cycles = b; term = 1'b0;
    @(negedge clk);
    start = 1'b0;
    // Start edge plus RST_CYCLES cycles: core held in reset, counters cleared.
    for (int j = 0; j <= RST_CYCLES; j++) begin
      check("rstph core_rst", core_rst, 1);
      check("rstph busy", busy, 1);
      check("rstph done", done, 0);
      check("rstph cnt", cycle_cnt, 0);
      start = 1'($urandom_range(0, 1));
      term  = 1'($urandom_range(0, 1));
      max_cycles = $urandom;
      @(negedge clk);
    end
    for (int r = 1; r <= stop_at; r++) begin
      check("run cnt", cycle_cnt, 64'(r - 1));
      check("run core_rst", core_rst, 0);
      check("run busy", busy, 1);
      check("run done", done, 0);
      term  = (r == k);
      start = 1'($urandom_range(0, 1));
      max_cycles = $urandom;
      @(negedge clk);
    end
    start = 1'b0;
    for (int h = 0; h < 3; h++) begin
      check("done done", done, 1);
      check("done busy", busy, 0);
      check("done core_rst", core_rst, 0);
      check("done timeout", timeout, exp_to);
      check("done cnt", cycle_cnt, 64'(stop_at));
      term = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    term = 1'b0;
  endtask

  initial begin
    // Reset held 3 cycles with start asserted.
    rst = 1'b1; start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_idle("reset");
    end
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    check_idle("idle");

    do_run(0, 10);   // unlimited budget, terminate on cycle 10
    do_run(5, 0);    // budget expiry
    do_run(5, 5);    // terminate and expiry coincide
    do_run(1, 0);    // smallest budget
    do_run(0, 1);    // terminate on first RUN cycle

    // rst pulse during RUN cycle 4.
    start = 1'b1; max_cycles = 0;
    @(negedge clk);
    start = 1'b0;
    for (int j = 0; j <= RST_CYCLES; j++) @(negedge clk);
    for (int r = 1; r < 4; r++) @(negedge clk);
    check("midrun cnt", cycle_cnt, 3);
    check("midrun core_rst", core_rst, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle("midrun_rst");
    @(negedge clk);
    check_idle("after_rst");

    // Randomized runs against the reference rule.
    for (int n = 0; n < 15; n++) begin
      int b, k;
      b = $urandom_range(0, 12);
      k = $urandom_range(0, 15);
      if (b == 0 && k == 0) k = $urandom_range(1, 15);
      do_run(b, k);
    end

    // Saturation on the 4-bit instance: unlimited budget, 20 RUN cycles.
    start4 = 1'b1; max4 = 0;
    @(negedge clk);
    start4 = 1'b0;
    for (int j = 0; j <= RST_CYCLES; j++) begin
      check("sat rstph core_rst", core_rst4, 1);
      @(negedge clk);
    end
    for (int r = 1; r <= 20; r++) begin
      check("sat cnt", cycle_cnt4, 64'((r - 1) > 15 ? 15 : (r - 1)));
      check("sat done", done4, 0);
      @(negedge clk);
    end
    $display("sat: cnt4=%0d after 20 RUN cycles", cycle_cnt4);
    check("sat final cnt", cycle_cnt4, 15);
    check("sat final done", done4, 0);
    check("sat busy", busy4, 1);
    term4 = 1'b1;
    @(negedge clk);
    term4 = 1'b0;
    check("sat term done", done4, 1);
    check("sat term timeout", timeout4, 0);
    check("sat term cnt", cycle_cnt4, 15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
